glyph_raster_sequencer: RTL and testbench

- Sequences the 8x16 character-generator ROM for the text layer of the LCD demo.
- Accepts one character cell at a time as an ASCII code plus foreground/background RGB565 colours.
- Walks the cell row-major by issuing (ascii, row, col) lookups to the ROM.
- Turns the returned 1-bit pixels into an RGB565 pixel stream with valid/ready backpressure toward the LCD pixel writer.

---
 rtl/glyph_raster_sequencer_pkg.sv | 11 +
 rtl/glyph_pixel_fifo.sv | 32 +++
 rtl/glyph_raster_sequencer.sv | 107 ++++++++++
 tb/tb_glyph_raster_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_raster_sequencer_pkg.sv
// glyph_raster_sequencer_pkg: shared glyph geometry, colour width, FSM encoding and the ROM credit rule.
package glyph_raster_sequencer_pkg;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int RGB_W = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;
    // A pop in the current cycle frees a slot, which keeps 1 pixel/clk with a 2-entry buffer.
    function automatic logic has_credit(input int depth, input int occ, input logic inflight, input logic pop);
        return occ + int'(inflight) < depth + int'(pop);
    endfunction
endpackage

// File: rtl/glyph_pixel_fifo.sv
// glyph_pixel_fifo: small DEPTH x W circular buffer of (pixel, last) entries with occupancy count.
module glyph_pixel_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 2) ? 2 : 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign dout = mem[rp];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) mem[wp] <= din;
            if (push) wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            if (pop) rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/glyph_raster_sequencer.sv
// glyph_raster_sequencer: walks an 8x16 glyph through the external char ROM and streams RGB565 pixels.
// Define GLYPH_SCALE2_EN to render each glyph at 16x32 (every column and row emitted twice).
module glyph_raster_sequencer
    import glyph_raster_sequencer_pkg::*;
#(
    parameter int CHAR_W = GLYPH_W,
    parameter int CHAR_H = GLYPH_H,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_ascii,
    input  logic [RGB_W-1:0] req_fg,
    input  logic [RGB_W-1:0] req_bg,
    output logic [6:0]       rom_ascii,
    output logic [3:0]       rom_row,
    output logic [2:0]       rom_col,
    input  logic             rom_pixel,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [RGB_W-1:0] pix_data,
    output logic             pix_last,
    output logic             busy
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    state_t state;
    logic [6:0] ascii;
    logic [RGB_W-1:0] fg, bg;
    logic [3:0] row;
    logic [2:0] col;
    logic sx, sy, inflight, inflight_last, pop, issue, last_issue, at_col_end;
    logic [1:0] head;
    logic [CW-1:0] count;
    assign pop = pix_valid & pix_ready;
    assign issue = state == ISSUE && has_credit(FIFO_DEPTH, int'(count), inflight, pop);
    assign at_col_end = col == 3'(CHAR_W - 1);
    assign last_issue = issue && row == 4'(CHAR_H - 1) && at_col_end && sx && sy;
    assign rom_ascii = ascii;
    assign rom_row = row;
    assign rom_col = col;
    assign pix_valid = count != '0;
    assign pix_data = head[1] ? fg : bg;
    assign pix_last = pix_valid & head[0];
    assign req_ready = state == IDLE && !rst;
    assign busy = state != IDLE;
`ifdef GLYPH_SCALE2_EN
    // sx repeats each column, sy repeats each row pass; both sit ahead of col/row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx <= 1'b0;
            sy <= 1'b0;
        end else if (state == IDLE) begin
            sx <= 1'b0;
            sy <= 1'b0;
        end else if (issue && !last_issue) begin
            sx <= ~sx;
            if (sx && at_col_end) sy <= ~sy;
        end
    end
`else
    assign sx = 1'b1;
    assign sy = 1'b1;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ascii <= '0;
            fg <= '0;
            bg <= '0;
            row <= '0;
            col <= '0;
            inflight <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= issue;
            inflight_last <= last_issue;
            case (state)
                IDLE: if (req_valid) begin
                    ascii <= req_ascii;
                    fg <= req_fg;
                    bg <= req_bg;
                    row <= '0;
                    col <= '0;
                    state <= ISSUE;
                end
                ISSUE: if (last_issue) state <= DRAIN;
                else if (issue) begin
                    if (sx) col <= at_col_end ? '0 : col + 1'b1;
                    if (sx && sy && at_col_end) row <= row + 1'b1;
                end
                DRAIN: if (pop && pix_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    glyph_pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(2)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(inflight),
        .din({rom_pixel, inflight_last}),
        .pop(pop),
        .dout(head),
        .count(count)
    );
endmodule

// File: tb/tb_glyph_raster_sequencer.sv
// tb_glyph_raster_sequencer: randomized self-checking bench with a hashed-bitmap ROM and pixel-stream reference model.
module tb_glyph_raster_sequencer;
`ifdef GLYPH_SCALE2_EN
    localparam int SC = 2;
`else
    localparam int SC = 1;
`endif
    localparam int NPIX = 128 * SC * SC;
    logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, rom_pixel = 1'b0, pix_ready = 1'b0;
    logic [6:0] req_ascii = '0;
    logic [15:0] req_fg = '0, req_bg = '0;
    logic req_ready, pix_valid, pix_last, busy;
    logic [6:0] rom_ascii;
    logic [3:0] rom_row;
    logic [2:0] rom_col;
    logic [15:0] pix_data;
    int tests = 0, fails = 0;
    logic [15:0] q_data[$];
    logic q_last[$];
    logic [6:0] q_addr[$];
    int first_v, last_c, unstable, busy_low, max_occ;

    glyph_raster_sequencer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_ascii(req_ascii), .req_fg(req_fg), .req_bg(req_bg),
        .rom_ascii(rom_ascii), .rom_row(rom_row), .rom_col(rom_col), .rom_pixel(rom_pixel),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_last(pix_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic gbit(input logic [6:0] a, input logic [3:0] r, input logic [2:0] c);
        logic [31:0] h;
        h = {18'd0, a, r, c} * 32'h9E3779B1;
        return h[19] ^ h[7];
    endfunction

    always @(posedge clk) rom_pixel <= gbit(rom_ascii, rom_row, rom_col);

    // Glyph cell {row,col} that output pixel k is taken from.
    function automatic logic [6:0] src(input int k);
        int x, y;
        x = k % (8 * SC);
        y = k / (8 * SC);
        return {4'(y / SC), 3'(x / SC)};
    endfunction

    function automatic logic [15:0] exp_pix(input logic [6:0] a, input logic [15:0] f, input logic [15:0] b, input int k);
        logic [6:0] s;
        s = src(k);
        return gbit(a, s[6:3], s[2:0]) ? f : b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [6:0] a, input logic [15:0] f, input logic [15:0] b);
        int w;
        req_ascii = a;
        req_fg = f;
        req_bg = b;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 300) begin
            step();
            w++;
        end
        step();
        req_valid = 1'b0;
        req_ascii = 7'($urandom);
        req_fg = 16'($urandom);
        req_bg = 16'($urandom);
    endtask

    task automatic collect(input int n, input int stall);
        logic held, hl;
        logic [15:0] hd;
        int cyc;
        q_data = {};
        q_last = {};
        q_addr = {};
        first_v = -1;
        last_c = -1;
        unstable = 0;
        busy_low = 0;
        max_occ = 0;
        held = 1'b0;
        hd = '0;
        hl = 1'b0;
        cyc = 0;
        while (q_data.size() < n && cyc < 40 * n + 100) begin
            pix_ready = $urandom_range(99) >= stall;
            if (q_addr.size() < 16) q_addr.push_back({rom_row, rom_col});
            if (int'(dut.u_fifo.count) > max_occ) max_occ = int'(dut.u_fifo.count);
            if (!busy) busy_low++;
            if (pix_valid && first_v < 0) first_v = cyc;
            if (held && (!pix_valid || pix_data !== hd || pix_last !== hl)) unstable++;
            held = pix_valid && !pix_ready;
            hd = pix_data;
            hl = pix_last;
            if (pix_valid && pix_ready) begin
                q_data.push_back(pix_data);
                q_last.push_back(pix_last);
                last_c = cyc;
            end
            step();
            cyc++;
        end
        pix_ready = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        tests++;
        if ({req_ready, pix_valid, pix_last, busy, pix_data, rom_ascii, rom_row, rom_col} !== '0) begin
            fails++;
            $display("FAIL reset_vals got rdy=%b v=%b l=%b busy=%b d=%h rom=%h/%h/%h want all 0",
                req_ready, pix_valid, pix_last, busy, pix_data, rom_ascii, rom_row, rom_col);
        end
        #3 rst = 1'b0;
        step();
        tests++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release got rdy=%b busy=%b want 1 0", req_ready, busy);
        end
    endtask

    task automatic test_basic();
        int bad, nl;
        accept(7'h41, 16'hFFFF, 16'h0000);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL basic_accept got busy=%b want 1", busy); end
        collect(NPIX, 0);
        tests++;
        if (q_data.size() != NPIX) begin fails++; $display("FAIL basic_count got %0d want %0d", q_data.size(), NPIX); end
        tests++;
        if (first_v != 2) begin fails++; $display("FAIL basic_latency got %0d want 2", first_v); end
        tests++;
        if (last_c != NPIX + 1) begin fails++; $display("FAIL basic_contig got last cycle %0d want %0d", last_c, NPIX + 1); end
        bad = 0;
        nl = 0;
        foreach (q_data[k]) begin
            if (q_data[k] !== exp_pix(7'h41, 16'hFFFF, 16'h0000, k)) bad++;
            if (q_last[k]) nl++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL basic_stream got %0d wrong pixels want 0", bad); end
        tests++;
        if (nl != 1 || q_last.size() != NPIX || q_last[NPIX-1] !== 1'b1) begin
            fails++;
            $display("FAIL basic_last got %0d last flags want exactly 1 at pixel %0d", nl, NPIX - 1);
        end
        bad = 0;
        foreach (q_addr[k]) if (q_addr[k] !== src(k)) bad++;
        tests++;
        if (bad != 0 || q_addr.size() != 16) begin fails++; $display("FAIL basic_rom_seq got %0d wrong addresses want 0", bad); end
        tests++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_done got busy=%b rdy=%b want 0 1", busy, req_ready);
        end
    endtask

    task automatic test_random_stall();
        int bad;
        accept(7'h7F, 16'hF800, 16'h001F);
        collect(NPIX, 30);
        tests++;
        if (q_data.size() != NPIX) begin fails++; $display("FAIL stall_count got %0d want %0d", q_data.size(), NPIX); end
        bad = 0;
        foreach (q_data[k]) if (q_data[k] !== exp_pix(7'h7F, 16'hF800, 16'h001F, k) || q_last[k] !== (k == NPIX - 1)) bad++;
        tests++;
        if (bad != 0) begin fails++; $display("FAIL stall_stream got %0d wrong pixels want 0", bad); end
        tests++;
        if (unstable != 0) begin fails++; $display("FAIL stall_stable got %0d changes while held want 0", unstable); end
        tests++;
        if (max_occ > 2) begin fails++; $display("FAIL stall_occupancy got %0d want <=2", max_occ); end
        tests++;
        if (busy_low != 0) begin fails++; $display("FAIL stall_busy got %0d idle cycles want 0", busy_low); end
    endtask

    task automatic test_back_to_back();
        int bad;
        logic [15:0] first_q[$];
        req_ascii = 7'h30;
        req_fg = 16'h1234;
        req_bg = 16'hABCD;
        req_valid = 1'b1;
        step();
        req_ascii = 7'h31;
        req_fg = 16'h5A5A;
        req_bg = 16'h0F0F;
        collect(NPIX, 0);
        first_q = q_data;
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b want 1 after last handshake", req_ready); end
        step();
        req_valid = 1'b0;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
        collect(NPIX, 0);
        bad = 0;
        foreach (first_q[k]) if (first_q[k] !== exp_pix(7'h30, 16'h1234, 16'hABCD, k)) bad++;
        foreach (q_data[k]) if (q_data[k] !== exp_pix(7'h31, 16'h5A5A, 16'h0F0F, k)) bad++;
        tests++;
        if (bad != 0 || first_q.size() + q_data.size() != 2 * NPIX) begin
            fails++;
            $display("FAIL b2b_stream got %0d wrong of %0d pixels want 0 of %0d", bad, first_q.size() + q_data.size(), 2 * NPIX);
        end
        tests++;
        if (first_v != 2) begin fails++; $display("FAIL b2b_latency got %0d want 2", first_v); end
    endtask

    task automatic test_reset_mid();
        int bad;
        accept(7'h23, 16'hC0DE, 16'h7777);
        collect(60, 0);
        rst = 1'b1;
        #1;
        tests++;
        if ({req_ready, pix_valid, pix_last, busy, pix_data, rom_ascii, rom_row, rom_col} !== '0) begin
            fails++;
            $display("FAIL rst_mid got rdy=%b v=%b l=%b busy=%b d=%h rom=%h/%h/%h want all 0",
                req_ready, pix_valid, pix_last, busy, pix_data, rom_ascii, rom_row, rom_col);
        end
        #2 rst = 1'b0;
        step();
        accept(7'h42, 16'h00FF, 16'hFF00);
        tests++;
        if (rom_row !== 4'd0 || rom_col !== 3'd0 || rom_ascii !== 7'h42) begin
            fails++;
            $display("FAIL rst_restart got %h/%h/%h want 42/0/0", rom_ascii, rom_row, rom_col);
        end
        collect(NPIX, 0);
        bad = 0;
        foreach (q_data[k]) if (q_data[k] !== exp_pix(7'h42, 16'h00FF, 16'hFF00, k) || q_last[k] !== (k == NPIX - 1)) bad++;
        tests++;
        if (bad != 0 || q_data.size() != NPIX) begin
            fails++;
            $display("FAIL rst_stream got %0d wrong of %0d want 0 of %0d", bad, q_data.size(), NPIX);
        end
    endtask

    task automatic test_stall10();
        int bad, hold_bad;
        logic [6:0] exp_a;
        pix_ready = 1'b0;
        accept(7'h55, 16'hBEEF, 16'h0101);
        exp_a = src(2);
        bad = 0;
        hold_bad = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i >= 2 && (!pix_valid || pix_data !== exp_pix(7'h55, 16'hBEEF, 16'h0101, 0))) bad++;
            if (i >= 2 && {rom_row, rom_col} !== exp_a) hold_bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL stall10_first got %0d bad cycles want 0", bad); end
        tests++;
        if (hold_bad != 0) begin
            fails++;
            $display("FAIL stall10_lookups got rom=%h/%h want %h/%h", rom_row, rom_col, exp_a[6:3], exp_a[2:0]);
        end
        collect(NPIX, 0);
        bad = 0;
        foreach (q_data[k]) if (q_data[k] !== exp_pix(7'h55, 16'hBEEF, 16'h0101, k) || q_last[k] !== (k == NPIX - 1)) bad++;
        tests++;
        if (bad != 0 || q_data.size() != NPIX) begin
            fails++;
            $display("FAIL stall10_stream got %0d wrong of %0d want 0 of %0d", bad, q_data.size(), NPIX);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_random_stall();
        test_back_to_back();
        test_reset_mid();
        test_stall10();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
